// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and defaults for the banked load/store unit
package mem_access_pkg;

    localparam int D_DEFAULT = 6;
    localparam int W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } bank_sel_t;

endpackage

// File: rtl/mem_access_unit_bank_router.sv
// rtl/mem_access_unit_bank_router.sv - splits a word request into even/odd bank accesses
module bank_router
    import mem_access_pkg::*;
#(
    parameter int D = D_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic [D:0]     addr,
    input  logic           wide,
    input  logic           write,
    input  logic [2*W-1:0] wdata,
    output logic           even_use,
    output logic           odd_use,
    output logic           even_we,
    output logic           odd_we,
    output logic [D-1:0]   even_addr,
    output logic [D-1:0]   odd_addr,
    output logic [W-1:0]   even_wdata,
    output logic [W-1:0]   odd_wdata,
    output logic           swap
);

    bank_sel_t    bank;
    logic [D-1:0] idx;
    logic [D-1:0] idx_next;

    assign bank     = bank_sel_t'(addr[0]);
    assign idx      = addr[D:1];
    assign idx_next = idx + D'(1);
    // swap: the low word lives in the odd bank
    assign swap     = (bank == ODD);

    always_comb begin
        even_use   = 1'b0;
        odd_use    = 1'b0;
        even_addr  = '0;
        odd_addr   = '0;
        even_wdata = '0;
        odd_wdata  = '0;
        if (wide) begin
            even_use = 1'b1;
            odd_use  = 1'b1;
            if (bank == EVEN) begin
                even_addr  = idx;
                odd_addr   = idx;
                even_wdata = wdata[W-1:0];
                odd_wdata  = wdata[2*W-1:W];
            end else begin
                odd_addr   = idx;
                odd_wdata  = wdata[W-1:0];
                even_addr  = idx_next;
                even_wdata = wdata[2*W-1:W];
            end
        end else if (bank == EVEN) begin
            even_use   = 1'b1;
            even_addr  = idx;
            even_wdata = wdata[W-1:0];
        end else begin
            odd_use   = 1'b1;
            odd_addr  = idx;
            odd_wdata = wdata[W-1:0];
        end
    end

    assign even_we = write & even_use;
    assign odd_we  = write & odd_use;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - one-at-a-time load/store front end for the even/odd data banks
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int D = D_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic           req_wide,
    input  logic [D:0]     req_addr,
    input  logic [2*W-1:0] req_wdata,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_rdata,
    output logic           even_we,
    output logic           odd_we,
    output logic [D-1:0]   even_addr,
    output logic [D-1:0]   odd_addr,
    output logic [W-1:0]   even_wdata,
    output logic [W-1:0]   odd_wdata,
    input  logic [W-1:0]   even_rdata,
    input  logic [W-1:0]   odd_rdata
);

    state_t         state_q, state_d;
    logic           even_we_q, even_we_d, odd_we_q, odd_we_d;
    logic [D-1:0]   even_addr_q, even_addr_d, odd_addr_q, odd_addr_d;
    logic [W-1:0]   even_wdata_q, even_wdata_d, odd_wdata_q, odd_wdata_d;
    logic           wide_q, wide_d, write_q, write_d, swap_q, swap_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic           r_even_use, r_odd_use, r_even_we, r_odd_we, r_swap;
    logic [D-1:0]   r_even_addr, r_odd_addr;
    logic [W-1:0]   r_even_wdata, r_odd_wdata;

    bank_router #(.D(D), .W(W)) u_router (
        .addr       (req_addr),
        .wide       (req_wide),
        .write      (req_write),
        .wdata      (req_wdata),
        .even_use   (r_even_use),
        .odd_use    (r_odd_use),
        .even_we    (r_even_we),
        .odd_we     (r_odd_we),
        .even_addr  (r_even_addr),
        .odd_addr   (r_odd_addr),
        .even_wdata (r_even_wdata),
        .odd_wdata  (r_odd_wdata),
        .swap       (r_swap)
    );

    always_comb begin
        state_d      = state_q;
        even_we_d    = even_we_q;
        odd_we_d     = odd_we_q;
        even_addr_d  = even_addr_q;
        odd_addr_d   = odd_addr_q;
        even_wdata_d = even_wdata_q;
        odd_wdata_d  = odd_wdata_q;
        wide_d       = wide_q;
        write_d      = write_q;
        swap_d       = swap_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    even_we_d = r_even_we;
                    odd_we_d  = r_odd_we;
                    // an unused bank keeps presenting its previous address and data
                    if (r_even_use) begin
                        even_addr_d  = r_even_addr;
                        even_wdata_d = r_even_wdata;
                    end
                    if (r_odd_use) begin
                        odd_addr_d  = r_odd_addr;
                        odd_wdata_d = r_odd_wdata;
                    end
                    wide_d  = req_wide;
                    write_d = req_write;
                    swap_d  = r_swap;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                even_we_d   = 1'b0;
                odd_we_d    = 1'b0;
                rsp_valid_d = 1'b1;
                if (write_q) begin
                    rsp_rdata_d = '0;
                end else if (wide_q) begin
                    rsp_rdata_d = swap_q ? {even_rdata, odd_rdata} : {odd_rdata, even_rdata};
                end else begin
                    rsp_rdata_d = swap_q ? {{W{1'b0}}, odd_rdata} : {{W{1'b0}}, even_rdata};
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            even_we_q    <= 1'b0;
            odd_we_q     <= 1'b0;
            even_addr_q  <= '0;
            odd_addr_q   <= '0;
            even_wdata_q <= '0;
            odd_wdata_q  <= '0;
            wide_q       <= 1'b0;
            write_q      <= 1'b0;
            swap_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            even_we_q    <= even_we_d;
            odd_we_q     <= odd_we_d;
            even_addr_q  <= even_addr_d;
            odd_addr_q   <= odd_addr_d;
            even_wdata_q <= even_wdata_d;
            odd_wdata_q  <= odd_wdata_d;
            wide_q       <= wide_d;
            write_q      <= write_d;
            swap_q       <= swap_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign even_we    = even_we_q;
    assign odd_we     = odd_we_q;
    assign even_addr  = even_addr_q;
    assign odd_addr   = odd_addr_q;
    assign even_wdata = even_wdata_q;
    assign odd_wdata  = odd_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - bench for mem_access_unit with bank models and flat-memory reference
module tb_mem_access_unit;

    localparam int D = 6;
    localparam int W = 32;
    localparam int NWORDS = 2 ** (D + 1);

    typedef struct {
        logic          write;
        logic          wide;
        logic [D:0]    addr;
        logic [63:0]   wdata;
        logic [63:0]   exp_rdata;
        logic          exp_even_we;
        logic          exp_odd_we;
        logic [D-1:0]  exp_even_addr;
        logic [D-1:0]  exp_odd_addr;
        logic [W-1:0]  exp_even_wdata;
        logic [W-1:0]  exp_odd_wdata;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid, req_ready, req_write, req_wide;
    logic [D:0]     req_addr;
    logic [2*W-1:0] req_wdata;
    logic           rsp_valid, rsp_ready;
    logic [2*W-1:0] rsp_rdata;
    logic           even_we, odd_we;
    logic [D-1:0]   even_addr, odd_addr;
    logic [W-1:0]   even_wdata, odd_wdata, even_rdata, odd_rdata;

    logic [W-1:0]   even_mem [2**D];
    logic [W-1:0]   odd_mem  [2**D];
    logic [W-1:0]   ref_mem  [NWORDS];
    logic [D-1:0]   last_even, last_odd;
    int             n_vec = 0;
    int             n_err = 0;

    mem_access_unit #(.D(D), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_wide   (req_wide),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .even_we    (even_we),
        .odd_we     (odd_we),
        .even_addr  (even_addr),
        .odd_addr   (odd_addr),
        .even_wdata (even_wdata),
        .odd_wdata  (odd_wdata),
        .even_rdata (even_rdata),
        .odd_rdata  (odd_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // Banks: negedge-sampled, write or read, never both
    initial begin
        for (int i = 0; i < 2**D; i++) begin
            even_mem[i] = init_word(2 * i);
            odd_mem[i]  = init_word(2 * i + 1);
        end
        even_rdata = '0;
        odd_rdata  = '0;
        forever begin
            @(negedge clk);
            if (even_we) even_mem[even_addr] = even_wdata;
            else         even_rdata = even_mem[even_addr];
            if (odd_we)  odd_mem[odd_addr] = odd_wdata;
            else         odd_rdata = odd_mem[odd_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic wd, input logic [D:0] a,
                                input logic [63:0] data, input logic [63:0] rd,
                                input logic ewe, input logic owe,
                                input logic [D-1:0] ea, input logic [D-1:0] oa,
                                input logic [W-1:0] ew, input logic [W-1:0] ow);
        vec_t v;
        v.write = wr; v.wide = wd; v.addr = a; v.wdata = data; v.exp_rdata = rd;
        v.exp_even_we = ewe; v.exp_odd_we = owe;
        v.exp_even_addr = ea; v.exp_odd_addr = oa;
        v.exp_even_wdata = ew; v.exp_odd_wdata = ow;
        return v;
    endfunction

    // Reference: a flat word array; unit address u lives in bank u%2 at index u/2
    function automatic vec_t model_vec(input logic wr, input logic wd, input logic [D:0] a,
                                       input logic [63:0] data);
        vec_t v;
        logic [D:0] u;
        v = mk(wr, wd, a, data, 64'd0, 1'b0, 1'b0, last_even, last_odd, '0, '0);
        for (int k = 0; k < (wd ? 2 : 1); k++) begin
            u = (a + (D+1)'(k)) % NWORDS;
            if (u % 2 == 0) begin
                v.exp_even_addr  = u / 2;
                v.exp_even_we    = wr;
                v.exp_even_wdata = data[k*W +: W];
            end else begin
                v.exp_odd_addr   = u / 2;
                v.exp_odd_we     = wr;
                v.exp_odd_wdata  = data[k*W +: W];
            end
        end
        if (!wr) begin
            u = (a + (D+1)'(1)) % NWORDS;
            v.exp_rdata = wd ? {ref_mem[u], ref_mem[a]} : {32'd0, ref_mem[a]};
        end
        return v;
    endfunction

    function automatic void model_commit(input vec_t v);
        logic [D:0] u;
        if (v.write) begin
            ref_mem[v.addr] = v.wdata[W-1:0];
            u = (v.addr + (D+1)'(1)) % NWORDS;
            if (v.wide) ref_mem[u] = v.wdata[2*W-1:W];
        end
        last_even = v.exp_even_addr;
        last_odd  = v.exp_odd_addr;
    endfunction

    task automatic run_vec(input string tag, input vec_t v, input int bp);
        int cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (req_ready !== 1'b1) begin
            chk({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1; req_write = v.write; req_wide = v.wide;
        req_addr = v.addr; req_wdata = v.wdata;
        rsp_ready = (bp == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = v.addr ^ 7'h2A;
        req_wdata = ~v.wdata;
        chk({tag, "_even_we"}, 64'(even_we), 64'(v.exp_even_we));
        chk({tag, "_odd_we"}, 64'(odd_we), 64'(v.exp_odd_we));
        chk({tag, "_even_addr"}, 64'(even_addr), 64'(v.exp_even_addr));
        chk({tag, "_odd_addr"}, 64'(odd_addr), 64'(v.exp_odd_addr));
        if (v.exp_even_we) chk({tag, "_even_wdata"}, 64'(even_wdata), 64'(v.exp_even_wdata));
        if (v.exp_odd_we)  chk({tag, "_odd_wdata"}, 64'(odd_wdata), 64'(v.exp_odd_wdata));
        chk({tag, "_access_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_access_req_ready"}, 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_we_cleared"}, 64'({even_we, odd_we}), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, v.exp_rdata);
            chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_req_ready_back"}, 64'(req_ready), 64'd1);
        rsp_ready = 1'b0;
        model_commit(v);
    endtask

    vec_t tbl [10];
    vec_t rv;
    int   acc_at [$];
    int   bad;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        last_even = '0; last_odd = '0;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_bank_ctl", 64'({even_we, odd_we, even_addr, odd_addr}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        tbl[0] = mk(1, 0, 7'd5,   64'hDEADBEEF,            64'd0,                   0, 1, 0, 2,  0,            32'hDEADBEEF);
        tbl[1] = mk(0, 0, 7'd5,   64'd0,                   64'h00000000_DEADBEEF,   0, 0, 0, 2,  0,            0);
        tbl[2] = mk(1, 1, 7'd8,   64'h22222222_11111111,   64'd0,                   1, 1, 4, 4,  32'h11111111, 32'h22222222);
        tbl[3] = mk(0, 1, 7'd8,   64'd0,                   64'h22222222_11111111,   0, 0, 4, 4,  0,            0);
        tbl[4] = mk(1, 0, 7'd127, 64'hA,                   64'd0,                   0, 1, 4, 63, 0,            32'hA);
        tbl[5] = mk(1, 0, 7'd0,   64'hB,                   64'd0,                   1, 0, 0, 63, 32'hB,        0);
        tbl[6] = mk(0, 1, 7'd127, 64'd0,                   64'h0000000B_0000000A,   0, 0, 0, 63, 0,            0);
        tbl[7] = mk(1, 1, 7'd3,   64'h44444444_33333333,   64'd0,                   1, 1, 2, 1,  32'h44444444, 32'h33333333);
        tbl[8] = mk(0, 0, 7'd4,   64'd0,                   64'h00000000_44444444,   0, 0, 2, 1,  0,            0);
        tbl[9] = mk(0, 0, 7'd3,   64'd0,                   64'h00000000_33333333,   0, 0, 2, 1,  0,            0);
        for (int i = 0; i < 10; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i], (i == 1) ? 5 : (i % 2));

        // Reset during the access cycle of a wide store aborts it entirely
        req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1;
        req_addr = 7'd10; req_wdata = 64'h77777777_66666666; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_we_before", 64'({even_we, odd_we}), 64'b11);
        rst = 1'b1;
        #1;
        chk("abort_we_dropped", 64'({even_we, odd_we}), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        #1 rst = 1'b0;
        last_even = '0; last_odd = '0;
        @(posedge clk); #1;
        chk("abort_idle", 64'(req_ready), 64'd1);
        run_vec("after_abort", model_vec(0, 1, 7'd10, 64'd0), 0);

        // Back-to-back loads: one acceptance every three cycles
        rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b0; req_addr = 7'd5;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) acc_at.push_back(i);
            if (rsp_valid) chk("b2b_rdata", rsp_rdata, {32'd0, ref_mem[5]});
            @(posedge clk); #1;
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("b2b_accept_count", 64'(acc_at.size()), 64'd4);
        for (int i = 1; i < acc_at.size(); i++)
            chk("b2b_spacing", 64'(acc_at[i] - acc_at[i-1]), 64'd3);
        model_commit(model_vec(0, 0, 7'd5, 64'd0));

        for (int i = 0; i < 40; i++) begin
            rv = model_vec(1'($urandom), 1'($urandom),
                           (i % 8 == 0) ? 7'd127 : 7'($urandom_range(0, NWORDS - 1)),
                           {$urandom, $urandom});
            run_vec($sformatf("rnd%0d", i), rv, $urandom_range(0, 3));
        end

        bad = 0;
        for (int i = 0; i < NWORDS; i++)
            if (((i % 2 == 0) ? even_mem[i/2] : odd_mem[i/2]) !== ref_mem[i]) bad++;
        chk("final_mem_words_bad", 64'(bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end that sits directly upstream of the two banked data memories (even bank, odd bank; each 2^D words × W bits, negedge-sampled, read-when-not-writing). It accepts one request at a time from the pipeline over a valid/ready handshake. It splits each request by word address into even/odd bank accesses, supporting 1-word and 2-word (wide, any alignment) transfers. It returns a response over a second valid/ready handshake.

Parameters:
D, 6, bank depth bits (each bank holds 2^D words; unit address space is 2^(D+1) words)
W, 32, word width in bits

Ports:
clk  in  1  single clock; banks sample on its negedge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_wide  in  1  1 = two consecutive words, 0 = one word
req_addr  in  D+1  word address; bit 0 selects bank (0 = even, 1 = odd)
req_wdata  in  2W  store data; low word goes to req_addr, high word to req_addr+1
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  2W  load data, same word ordering as req_wdata; 0 for stores
even_we / odd_we  out  1  bank write enables
even_addr / odd_addr  out  D  bank word index
even_wdata / odd_wdata  out  W  bank write data
even_rdata / odd_rdata  in  W  bank read data

Behaviour:
- Reset (async, immediate): state IDLE; all bank outputs 0; rsp_valid 0; rsp_rdata 0; req_ready 0 while rst is high.
- Abort on reset: reset asserted mid-operation aborts the transfer. No response is produced, and the write enables drop immediately.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid at posedge: register the bank controls, latch the request type, go to ACCESS.
- Bank mapping, with idx = req_addr[D:1] and b = req_addr[0]:
  - Narrow: only bank b is used, at index idx. The other bank's we = 0 and its addr holds its previous value.
  - Wide, b=0: both banks at idx; low word maps to even, high word to odd.
  - Wide, b=1: odd bank at idx carries the low word; even bank at idx+1 (mod 2^D) carries the high word. The top address wraps to 0 with no error.
  - Writes assert we only on the banks used. Reads keep all we = 0.
- ACCESS (one cycle):
  - Bank outputs are held stable, so the memory samples them at the negedge.
  - At the next posedge: capture bank read data into rsp_rdata, clear both we, set rsp_valid = 1, go to RESP.
  - Narrow load: rsp_rdata = {W zeros, selected bank word}.
  - Wide load: {high word, low word} per the mapping above.
  - Store: rsp_rdata = 0.
- RESP:
  - rsp_valid and rsp_rdata are held stable until rsp_ready = 1 at a posedge.
  - Then rsp_valid = 0 and the FSM returns to IDLE. req_ready rises the following cycle (no bypass).
- Latency: rsp_valid is high 2 posedges after acceptance. Throughput is at most 1 request per 3 cycles with rsp_ready tied high.
- Ignored inputs: req_valid outside IDLE, and req_wdata/req_addr changes after acceptance.
- Each write enable is high for exactly one clock period per store.

Decomposition:
- Package mem_access_pkg holds:
  - enum state_t {IDLE, ACCESS, RESP}
  - typedef bank_sel_t (EVEN=0, ODD=1)
  - Parameter defaults D=6, W=32
- One combinational sub-module, bank_router: maps (addr, wide, write, wdata) to per-bank we/addr/wdata and a swap flag used by the read-data reassembly.

Test Plan:
- Narrow store 0xDEADBEEF to addr 5, then narrow load addr 5 -> only odd_we pulses, odd_addr=2 for one cycle; load returns rsp_rdata=0x00000000_DEADBEEF, rsp_valid 2 cycles after acceptance.
- Wide aligned store {0x22222222,0x11111111} to addr 8, then wide load addr 8 -> even[4]=0x11111111, odd[4]=0x22222222; load returns 0x22222222_11111111.
- Wide misaligned load at addr 127 (D=6) with odd[63]=0xA, even[0]=0xB -> odd_addr=63, even_addr=0 (wrap); rsp_rdata=0x0000000B_0000000A.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; one cycle after the rsp_ready handshake, req_ready=1.
- Reset asserted during ACCESS of a wide store -> even_we/odd_we drop immediately, rsp_valid never rises, FSM in IDLE; the next request completes normally.
- Back-to-back narrow loads with req_valid held high and rsp_ready=1 -> exactly one acceptance per 3 cycles; the second request is not accepted during ACCESS/RESP.
